// File: rtl/dma_perf_timer.sv
// Multi-channel cycle timer for DMA transfers: start/stop strobes per channel,
// optional timeout, result held until the next start.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no measurement; counter 0 after reset/clear
// S_RUN  | counting cycles since start
// S_DONE | stopped by ch_stop; counter holds the measured cycles
// S_TOUT | timeout limit reached; counter holds the limit
module dma_perf_timer #(
    parameter int          NUM_CH  = 4,
    parameter int          WIDTH   = 32,
    parameter int unsigned TIMEOUT = 100,
    parameter bit          RESTART = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic [NUM_CH-1:0]       ch_start,
    input  logic [NUM_CH-1:0]       ch_stop,
    output logic [NUM_CH-1:0]       ch_busy,
    output logic [NUM_CH-1:0]       ch_done,
    output logic [NUM_CH-1:0]       ch_timeout,
    output logic [NUM_CH*WIDTH-1:0] ch_cycles,
    output logic                    all_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_TOUT = 2'd3
    } state_t;

    // A limit beyond the counter range is clamped to the largest count.
    localparam longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1;
    localparam longint unsigned TO_VAL  = 64'(TIMEOUT);
    localparam longint unsigned LIM_VAL = (TO_VAL > MAX_VAL) ? MAX_VAL : TO_VAL;
    localparam logic [WIDTH-1:0] LIMIT   = LIM_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t           r_state     [NUM_CH];
    logic [WIDTH-1:0] r_cnt       [NUM_CH];
    state_t           w_state_nxt [NUM_CH];
    logic [WIDTH-1:0] w_cnt_nxt   [NUM_CH];
    logic [WIDTH-1:0] w_cnt_inc   [NUM_CH];
    logic [NUM_CH-1:0] w_fin;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            // Saturating increment; only reachable at the top when timeout is off.
            w_cnt_inc[i]   = (r_cnt[i] == CNT_MAX) ? r_cnt[i] : r_cnt[i] + 1'b1;
            case (r_state[i])
                S_IDLE: begin
                    if (ch_start[i]) begin
                        w_state_nxt[i] = S_RUN;
                        w_cnt_nxt[i]   = '0;
                    end
                end
                S_RUN: begin
                    if (RESTART && ch_start[i]) begin
                        w_cnt_nxt[i] = '0;
                    end else if (ch_stop[i]) begin
                        w_state_nxt[i] = S_DONE;
                        w_cnt_nxt[i]   = w_cnt_inc[i];
                    end else if ((TIMEOUT != 0) && (w_cnt_inc[i] == LIMIT)) begin
                        w_state_nxt[i] = S_TOUT;
                        w_cnt_nxt[i]   = LIMIT;
                    end else begin
                        w_cnt_nxt[i] = w_cnt_inc[i];
                    end
                end
                S_DONE, S_TOUT: begin
                    if (ch_start[i]) begin
                        w_state_nxt[i] = S_RUN;
                        w_cnt_nxt[i]   = '0;
                    end
                end
                default: begin
                    w_state_nxt[i] = S_IDLE;
                    w_cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    always_comb begin
        ch_busy    = '0;
        ch_done    = '0;
        ch_timeout = '0;
        ch_cycles  = '0;
        w_fin      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_busy[i]                 = (r_state[i] == S_RUN);
            ch_done[i]                 = (r_state[i] == S_DONE);
            ch_timeout[i]              = (r_state[i] == S_TOUT);
            ch_cycles[i*WIDTH +: WIDTH] = r_cnt[i];
            w_fin[i]                   = (r_state[i] == S_DONE) || (r_state[i] == S_TOUT);
        end
        all_done = &w_fin;
    end

endmodule

// File: tb/tb_dma_perf_timer.sv
// Directed checks for dma_perf_timer: a per-cycle vector table on the default
// configuration plus hand-written timeout, saturation, restart and reset sequences.
module tb_dma_perf_timer;

    logic clk = 1'b0;
    logic rst_n;
    logic clr;

    logic [3:0]   a_start, a_stop, a_busy, a_done, a_tout;
    logic [127:0] a_cyc;
    logic         a_alld;

    logic [1:0]   b_start, b_stop, b_busy, b_done, b_tout;
    logic [15:0]  b_cyc;
    logic         b_alld;

    logic [0:0]   c_start, c_stop, c_busy, c_done, c_tout;
    logic [7:0]   c_cyc;
    logic         c_alld;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    dma_perf_timer #(.NUM_CH(4), .WIDTH(32), .TIMEOUT(100), .RESTART(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ch_start(a_start), .ch_stop(a_stop),
        .ch_busy(a_busy), .ch_done(a_done), .ch_timeout(a_tout), .ch_cycles(a_cyc),
        .all_done(a_alld));

    dma_perf_timer #(.NUM_CH(2), .WIDTH(8), .TIMEOUT(0), .RESTART(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ch_start(b_start), .ch_stop(b_stop),
        .ch_busy(b_busy), .ch_done(b_done), .ch_timeout(b_tout), .ch_cycles(b_cyc),
        .all_done(b_alld));

    dma_perf_timer #(.NUM_CH(1), .WIDTH(8), .TIMEOUT(300), .RESTART(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ch_start(c_start), .ch_stop(c_stop),
        .ch_busy(c_busy), .ch_done(c_done), .ch_timeout(c_tout), .ch_cycles(c_cyc),
        .all_done(c_alld));

    typedef struct {
        logic [3:0]  start;
        logic [3:0]  stop;
        logic        clr;
        logic [3:0]  busy;
        logic [3:0]  done;
        logic [3:0]  tout;
        logic [31:0] cyc0;
        logic        alld;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_start = '0; a_stop = '0;
        b_start = '0; b_stop = '0;
        c_start = '0; c_stop = '0;
        clr     = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    function automatic logic [31:0] acyc(input int ch);
        return a_cyc[ch*32 +: 32];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // start, stop, clr | busy, done, tout, cyc0, all_done
        vecs[0]  = '{4'h1, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 32'd0, 1'b0};
        vecs[1]  = '{4'h0, 4'h1, 1'b0, 4'h0, 4'h1, 4'h0, 32'd1, 1'b0};
        vecs[2]  = '{4'h0, 4'h1, 1'b0, 4'h0, 4'h1, 4'h0, 32'd1, 1'b0};
        vecs[3]  = '{4'h1, 4'h1, 1'b0, 4'h1, 4'h0, 4'h0, 32'd0, 1'b0};
        vecs[4]  = '{4'h1, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 32'd1, 1'b0};
        vecs[5]  = '{4'h0, 4'h0, 1'b0, 4'h1, 4'h0, 4'h0, 32'd2, 1'b0};
        vecs[6]  = '{4'h1, 4'h1, 1'b0, 4'h0, 4'h1, 4'h0, 32'd3, 1'b0};
        vecs[7]  = '{4'h0, 4'h2, 1'b0, 4'h0, 4'h1, 4'h0, 32'd3, 1'b0};
        vecs[8]  = '{4'h2, 4'h2, 1'b0, 4'h2, 4'h1, 4'h0, 32'd3, 1'b0};
        vecs[9]  = '{4'h1, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 32'd0, 1'b0};
        vecs[10] = '{4'hF, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, 32'd0, 1'b0};
        vecs[11] = '{4'h0, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, 32'd1, 1'b0};
        vecs[12] = '{4'h0, 4'hF, 1'b0, 4'h0, 4'hF, 4'h0, 32'd2, 1'b1};
        vecs[13] = '{4'h1, 4'h0, 1'b0, 4'h1, 4'hE, 4'h0, 32'd0, 1'b0};
        vecs[14] = '{4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 32'd0, 1'b0};

        idle_inputs();
        rst_n = 1'b0;
        ticks(2);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_tout", a_tout, 0);
        chk("rst_cycles", a_cyc, 0);
        chk("rst_all_done", a_alld, 0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 15; v++) begin
            a_start = vecs[v].start;
            a_stop  = vecs[v].stop;
            clr     = vecs[v].clr;
            tick();
            chk($sformatf("vec%0d_busy", v), a_busy, vecs[v].busy);
            chk($sformatf("vec%0d_done", v), a_done, vecs[v].done);
            chk($sformatf("vec%0d_tout", v), a_tout, vecs[v].tout);
            chk($sformatf("vec%0d_cyc0", v), acyc(0), vecs[v].cyc0);
            chk($sformatf("vec%0d_all_done", v), a_alld, vecs[v].alld);
        end
        idle_inputs();

        // Start ch0, stop 15 edges later.
        a_start = 4'h1; tick(); a_start = '0;
        ticks(14);
        chk("m15_busy_before_stop", a_busy, 4'h1);
        a_stop = 4'h1; tick(); a_stop = '0;
        chk("m15_done", a_done, 4'h1);
        chk("m15_cycles", acyc(0), 15);
        chk("m15_busy", a_busy, 0);
        chk("m15_all_done", a_alld, 0);
        tick();
        chk("m15_hold", acyc(0), 15);

        // Timeout on ch1 exactly 100 edges after start.
        a_start = 4'h2; tick(); a_start = '0;
        ticks(99);
        chk("to_cyc99", acyc(1), 99);
        chk("to_busy99", a_busy[1], 1);
        chk("to_tout99", a_tout[1], 0);
        tick();
        chk("to_tout100", a_tout[1], 1);
        chk("to_cyc100", acyc(1), 100);
        chk("to_busy100", a_busy[1], 0);
        a_stop = 4'h2; tick(); a_stop = '0;
        chk("to_stop_ignored", a_tout[1], 1);
        chk("to_stop_no_done", a_done[1], 0);

        // Stop coinciding with the timeout edge reports DONE at the limit.
        a_start = 4'h2; tick(); a_start = '0;
        chk("tostop_restart_tout", a_tout[1], 0);
        chk("tostop_restart_busy", a_busy[1], 1);
        ticks(99);
        a_stop = 4'h2; tick(); a_stop = '0;
        chk("tostop_done", a_done[1], 1);
        chk("tostop_tout", a_tout[1], 0);
        chk("tostop_cyc", acyc(1), 100);

        // All four channels: stops at 5/7/9, ch3 times out last.
        clr = 1'b1; tick(); clr = 1'b0;
        a_start = 4'hF; tick(); a_start = '0;
        for (int e = 1; e <= 99; e++) begin
            a_stop = {1'b0, e == 9, e == 7, e == 5};
            tick();
        end
        a_stop = '0;
        chk("all_pre_done", a_done, 4'h7);
        chk("all_pre_alld", a_alld, 0);
        tick();
        chk("all_alld", a_alld, 1);
        chk("all_tout", a_tout, 4'h8);
        chk("all_cyc0", acyc(0), 5);
        chk("all_cyc1", acyc(1), 7);
        chk("all_cyc2", acyc(2), 9);
        chk("all_cyc3", acyc(3), 100);
        a_start = 4'h1; tick(); a_start = '0;
        chk("all_drop", a_alld, 0);

        // Restart behaviour: A ignores the second start, B restarts.
        clr = 1'b1; tick(); clr = 1'b0;
        a_start = 4'h1; b_start = 2'b10; tick(); a_start = '0; b_start = '0;
        ticks(19);
        a_start = 4'h1; b_start = 2'b10; tick(); a_start = '0; b_start = '0;
        ticks(9);
        a_stop = 4'h1; b_stop = 2'b10; tick(); a_stop = '0; b_stop = '0;
        chk("rs0_cycles", acyc(0), 30);
        chk("rs1_cycles", b_cyc[15:8], 10);
        chk("rs1_done", b_done[1], 1);

        // Saturation with timeout disabled.
        clr = 1'b1; tick(); clr = 1'b0;
        b_start = 2'b01; tick(); b_start = '0;
        ticks(300);
        chk("sat_cycles", b_cyc[7:0], 255);
        chk("sat_busy", b_busy[0], 1);
        b_stop = 2'b01; tick(); b_stop = '0;
        chk("sat_done", b_done[0], 1);
        chk("sat_stop_cycles", b_cyc[7:0], 255);

        // Timeout above the counter range clamps to 255.
        c_start = 1'b1; tick(); c_start = '0;
        ticks(254);
        chk("clamp_busy254", c_busy, 1);
        chk("clamp_cyc254", c_cyc, 254);
        tick();
        chk("clamp_tout", c_tout, 1);
        chk("clamp_cyc", c_cyc, 255);

        // Reset mid-run discards the measurement and beats start/stop.
        clr = 1'b1; tick(); clr = 1'b0;
        a_start = 4'h4; tick(); a_start = '0;
        ticks(40);
        chk("mr_cyc40", acyc(2), 40);
        rst_n = 1'b0; a_start = 4'hF; a_stop = 4'hF; clr = 1'b1;
        tick();
        idle_inputs();
        rst_n = 1'b1;
        chk("mr_busy", a_busy, 0);
        chk("mr_done", a_done, 0);
        chk("mr_tout", a_tout, 0);
        chk("mr_cycles", a_cyc, 0);
        chk("mr_alld", a_alld, 0);
        tick();
        a_stop = 4'h4; tick(); a_stop = '0;
        chk("mr_stop_done", a_done[2], 0);
        chk("mr_stop_busy", a_busy[2], 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/dma_perf_timer.md
DMA_PERF_TIMER -- requirements
Module: dma_perf_timer

Interface
REQ-001 Parameter: NUM_CH, default 4, number of independent timing channels (1..16).
REQ-002 Parameter: WIDTH, default 32, bit width of each channel cycle counter (8..32).
REQ-003 Parameter: TIMEOUT, default 100, cycle limit per measurement; 0 disables timeout.
REQ-004 Parameter: RESTART, default 0; 1 = start while running restarts the measurement, 0 = start while running is ignored.
REQ-005 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-006 Port: rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-007 Port: clr  input  1  synchronous clear of all channels; identical effect to reset.
REQ-008 Port: ch_start  input  NUM_CH  per-channel start strobe, sampled every cycle.
REQ-009 Port: ch_stop  input  NUM_CH  per-channel stop strobe, sampled every cycle.
REQ-010 Port: ch_busy  output  NUM_CH  channel in RUN.
REQ-011 Port: ch_done  output  NUM_CH  channel in DONE; result valid.
REQ-012 Port: ch_timeout  output  NUM_CH  channel in TOUT; result held at TIMEOUT.
REQ-013 Port: ch_cycles  output  NUM_CH*WIDTH  packed counters; channel i at bits [i*WIDTH +: WIDTH].
REQ-014 Port: all_done  output  1  high when every channel is in DONE or TOUT.

Function
REQ-015 Each channel SHALL run an independent FSM with states IDLE, RUN, DONE, TOUT.
REQ-016 All outputs SHALL be registered or decoded from registered state only; no combinational input-to-output path.
REQ-017 IDLE: ch_start -> RUN, counter <= 0; ch_stop alone ignored; ch_start and ch_stop in the same cycle -> start wins, stop ignored.
REQ-018 RUN: every cycle counter <= counter + 1; if ch_stop is high that cycle -> DONE with the incremented value latched, so start at edge t and stop at edge t+k gives ch_cycles = k (k >= 1).
REQ-019 RUN: if TIMEOUT != 0, ch_stop is low and counter + 1 == TIMEOUT -> TOUT, counter = TIMEOUT.
REQ-020 RUN: ch_stop and timeout in the same cycle -> DONE, counter = TIMEOUT, ch_timeout stays low.
REQ-021 RUN with TIMEOUT == 0: counter SHALL saturate at 2^WIDTH-1 and SHALL NOT wrap; channel stays in RUN until stop.
REQ-022 RUN with ch_start: RESTART=1 -> counter <= 0, stay in RUN, and this takes priority over ch_stop in the same cycle; RESTART=0 -> start ignored, stop and count behave per REQ-018.
REQ-023 DONE/TOUT: counter held; ch_stop ignored; ch_start -> RUN, counter <= 0, done/timeout flag cleared the next cycle.
REQ-024 If TIMEOUT > 2^WIDTH-1, the effective limit SHALL be 2^WIDTH-1.
REQ-025 all_done SHALL be registered-state derived and update in the same cycle the last channel enters DONE/TOUT; it drops when any channel leaves.
REQ-026 clr high SHALL force all channels to IDLE with counter 0 and override ch_start/ch_stop that cycle.

Reset
REQ-027 While rst_n = 0 at a rising edge: all channels IDLE, counters 0, ch_busy = ch_done = ch_timeout = 0, all_done = 0.
REQ-028 Reset asserted mid-RUN SHALL discard the measurement; no flag asserts after rst_n returns high until a new start.
REQ-029 Reset SHALL take priority over clr, ch_start and ch_stop.

Verification
REQ-030 NUM_CH=4, TIMEOUT=100: start ch0 at cycle 10, stop at cycle 25 -> ch_done[0]=1 from cycle 26, ch_cycles[0]=15, other channels IDLE, all_done=0.
REQ-031 Start ch1, no stop -> ch_timeout[1]=1 exactly 100 cycles after start, ch_cycles[1]=100, ch_busy[1]=0.
REQ-032 All 4 channels started, stopped at 5/7/9 cycles and ch3 timed out -> all_done rises with the last transition; then restart ch0 -> all_done=0 next cycle.
REQ-033 WIDTH=8, TIMEOUT=0, no stop for 300 cycles -> ch_cycles=255 held, ch_busy=1; stop -> ch_done=1, value 255.
REQ-034 RESTART=1: start at t, start again at t+20, stop at t+30 -> ch_cycles=10; RESTART=0, same stimulus -> 30.
REQ-035 rst_n low for 1 cycle while ch2 is RUN at count 40 -> all outputs 0; ch_stop pulse afterwards -> ch_done[2] stays 0.
